mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares port B of the dual-port Memory between two requesters: req0 (CPU data side) and req1 (loader/DMA).
- Arbitration is round-robin, with an optional locked burst capped at MAX_BURST beats.
- Detects same-address write collisions with port A and stalls port B until the collision clears.
- Sits between the requesters and the Memory instance. Drives Address_B, Data_B and write_B, and consumes Out_B.

Parameters:
- dtype, 16, data word width.
- lines, 1000, memory depth.
- addr_len, $clog2(lines), address width.
- MAX_BURST, 4, maximum consecutive locked beats per grant (≥1).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request present (N=0,1)
- reqN_ready  out  1  request accepted this cycle
- reqN_write  in  1  1=write, 0=read
- reqN_lock  in  1  request to keep the grant for the next beat
- reqN_addr  in  addr_len  word address
- reqN_wdata  in  dtype  write data
- rspN_valid  out  1  read data valid
- rspN_rdata  out  dtype  read data
- mem_addr  out  addr_len  to Address_B
- mem_wdata  out  dtype  to Data_B
- mem_write  out  1  to write_B
- mem_rdata  in  dtype  from Out_B (asynchronous read)
- porta_write  in  1  snoop of write_A
- porta_addr  in  addr_len  snoop of Address_A

Behaviour:
- **Clock and reset:** one clock; reset is asynchronous and active-low (reset_n).
- **Reset values:** state=IDLE, owner=none, last_grant=1 (so req0 wins first), beat_cnt=0, rsp*_valid=0, rsp*_rdata=0.
- Outputs with combinational drivers (ready, mem_*) are 0 while reset_n=0.
- **State machine:**
  - States: IDLE (no owner), OWN0, OWN1.
  - Each cycle a selected requester `sel` is computed combinationally.
- **Selection rules:**
  - OWNn with reqn_valid=1: sel=n.
  - OWNn with reqn_valid=0: ownership is dropped this cycle and selection falls to the IDLE rule.
  - IDLE rule:
    - Only one valid: sel=that requester.
    - Both valid: sel=!last_grant.
    - Neither valid: no selection.
- **Mux:** mem_addr/mem_wdata follow sel. With no selection, mem_addr=0, mem_wdata=0, mem_write=0.
- **Collision:** collide = sel valid & sel write & porta_write & (sel addr == porta_addr).
- **Handshake:**
  - reqsel_ready = valid & !collide.
  - Non-selected ready=0.
  - mem_write = ready & write.
- **Collision stall:**
  - The requester holds valid and all fields stable while stalled.
  - Ownership and beat_cnt are unchanged during a stall.
  - A read to the same address as a port A write is not stalled and returns pre-write data.
- **Transfer (valid & ready):**
  - last_grant←sel.
  - If lock=1 and beat_cnt<MAX_BURST-1: state←OWNsel, beat_cnt←beat_cnt+1.
  - Otherwise: state←IDLE, beat_cnt←0.
- **Burst cap:** after MAX_BURST locked beats the grant is released. Because last_grant=owner, the other requester wins next if valid.
- **Read response:**
  - On a read transfer, rspsel_rdata←mem_rdata and rspsel_valid←1 at that clock edge.
  - Response is visible in the cycle after accept (latency 1).
  - rspN_valid is a 1-cycle pulse.
  - rspN_rdata holds its value until the next read response.
  - Back-to-back reads give consecutive pulses.
- **Write:** no response. Write completes at the accept edge.
- **Reset mid-burst:** ownership is released, a pending rsp_valid is cleared, and no memory write occurs while reset is asserted.
- **Address range:** not checked. Addresses ≥ lines are passed through unchanged.

Test Plan:
1. Reset, then req0 read addr 5 (mem[5]=0x1234) → req0_ready=1 in the same cycle; next cycle rsp0_valid=1, rsp0_rdata=0x1234; rsp1_valid stays 0.
2. Both valid every cycle, no lock → grants alternate 0,1,0,1. First grant is req0 after reset. Exactly one ready per cycle.
3. req0 lock=1 for 6 writes (addr 10..15) with req1 valid throughout, MAX_BURST=4 → req0 gets beats 10..13, req1 gets the next cycle, then req0 resumes at 14. mem[10..13] are written in 4 consecutive cycles.
4. req1 write addr 7 data 0xBEEF while porta_write=1, porta_addr=7 for 2 cycles → req1_ready=0 and mem_write=0 for 2 cycles, then accepted on cycle 3 with mem[7]=0xBEEF. Same scenario with a read → no stall.
5. req0 locked (beat 2), then reset_n dropped asynchronously mid-cycle → ready, mem_write and rsp_valid go 0 immediately. After release, req0 and req1 both valid → req0 granted first.
6. Locked owner req1 drops valid with req0 valid → req0_ready=1 in that same cycle; state leaves OWN1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares Memory port B between req0 (CPU data) and req1 (loader/DMA): round-robin
// grants, locked bursts capped at MAX_BURST beats, and a stall on same-address port A writes.
module mem_port_arbiter #(
    parameter int unsigned dtype     = 16,
    parameter int unsigned lines     = 1000,
    parameter int unsigned addr_len  = $clog2(lines),
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_write,
    input  logic                req0_lock,
    input  logic [addr_len-1:0] req0_addr,
    input  logic [dtype-1:0]    req0_wdata,
    output logic                rsp0_valid,
    output logic [dtype-1:0]    rsp0_rdata,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_write,
    input  logic                req1_lock,
    input  logic [addr_len-1:0] req1_addr,
    input  logic [dtype-1:0]    req1_wdata,
    output logic                rsp1_valid,
    output logic [dtype-1:0]    rsp1_rdata,
    output logic [addr_len-1:0] mem_addr,
    output logic [dtype-1:0]    mem_wdata,
    output logic                mem_write,
    input  logic [dtype-1:0]    mem_rdata,
    input  logic                porta_write,
    input  logic [addr_len-1:0] porta_addr
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic [dtype-1:0]    rsp0_rdata_q, rsp0_rdata_d;
    logic [dtype-1:0]    rsp1_rdata_q, rsp1_rdata_d;

    logic                sel_valid;
    logic                sel;
    logic                owner_kept;
    logic                sel_write;
    logic                sel_lock;
    logic [addr_len-1:0] sel_addr;
    logic [dtype-1:0]    sel_wdata;
    logic                collide;
    logic                xfer;
    logic [CNT_W-1:0]    cur_cnt;

    // Requester selection: a valid owner keeps the port, otherwise round-robin.
    always_comb begin
        sel_valid  = 1'b0;
        sel        = 1'b0;
        owner_kept = 1'b0;
        if (state_q == OWN0 && req0_valid) begin
            sel_valid  = 1'b1;
            owner_kept = 1'b1;
        end else if (state_q == OWN1 && req1_valid) begin
            sel_valid  = 1'b1;
            sel        = 1'b1;
            owner_kept = 1'b1;
        end else if (req0_valid && req1_valid) begin
            sel_valid = 1'b1;
            sel       = ~last_grant_q;
        end else if (req0_valid || req1_valid) begin
            sel_valid = 1'b1;
            sel       = req1_valid;
        end
        sel_write = sel ? req1_write : req0_write;
        sel_lock  = sel ? req1_lock  : req0_lock;
        sel_addr  = sel ? req1_addr  : req0_addr;
        sel_wdata = sel ? req1_wdata : req0_wdata;
        collide   = sel_valid & sel_write & porta_write & (sel_addr == porta_addr);
        xfer      = sel_valid & ~collide & reset_n;
        // A burst count only carries over while the same owner keeps the grant.
        cur_cnt   = owner_kept ? beat_cnt_q : '0;
    end

    // Next state, port B drive and read-response capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_write    = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        if (state_q != IDLE && !owner_kept) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
        end

        if (sel_valid && reset_n) begin
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
        mem_write  = xfer & sel_write;
        req0_ready = xfer & ~sel;
        req1_ready = xfer & sel;

        if (xfer) begin
            last_grant_d = sel;
            if (sel_lock && (cur_cnt < CNT_W'(MAX_BURST - 1))) begin
                state_d    = sel ? OWN1 : OWN0;
                beat_cnt_d = cur_cnt + CNT_W'(1);
            end else begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
            if (!sel_write) begin
                if (sel) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_rdata_d = mem_rdata;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_rdata_d = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked each
// cycle against a transaction-level model of grants, memory contents and responses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned DW    = 16;
    localparam int unsigned LINES = 1000;
    localparam int unsigned AW    = $clog2(LINES);
    localparam int unsigned MB    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef struct {
        bit            w;
        bit            lk;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    logic          clock;
    logic          reset_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic          req0_write, req1_write, req0_lock, req1_lock;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write;
    logic          porta_write;
    logic [AW-1:0] porta_addr;

    bit            tv [2];
    bit            tw [2];
    bit            tl [2];
    logic [AW-1:0] ta [2];
    logic [DW-1:0] td [2];
    bit            pa_w;
    logic [AW-1:0] pa_a;
    logic [DW-1:0] pa_d;

    assign req0_valid  = tv[0];
    assign req1_valid  = tv[1];
    assign req0_write  = tw[0];
    assign req1_write  = tw[1];
    assign req0_lock   = tl[0];
    assign req1_lock   = tl[1];
    assign req0_addr   = ta[0];
    assign req1_addr   = ta[1];
    assign req0_wdata  = td[0];
    assign req1_wdata  = td[1];
    assign porta_write = pa_w;
    assign porta_addr  = pa_a;

    mem_port_arbiter #(
        .dtype(DW), .lines(LINES), .addr_len(AW), .MAX_BURST(MB)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .porta_write(porta_write), .porta_addr(porta_addr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 5) ? 16'h1234 : DW'(i * 37 + 11);
    endfunction

    // Dual-port memory environment: asynchronous read on B, writes from both ports.
    logic [DW-1:0] env_mem [DEPTH];
    bit            env_init_done;
    always @(posedge clock) begin
        if (!env_init_done) begin
            for (int i = 0; i < int'(DEPTH); i++) env_mem[i] <= init_word(i);
            env_init_done <= 1'b1;
        end else begin
            if (mem_write)   env_mem[mem_addr]   <= mem_wdata;
            if (porta_write) env_mem[porta_addr] <= pa_d;
        end
    end
    assign mem_rdata = env_mem[mem_addr];

    int n_cmp;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int            m_owner;
    int            m_last;
    int            m_beats;
    logic [DW-1:0] m_mem [DEPTH];
    bit            exp_rv [2];
    logic [DW-1:0] exp_rd [2];

    req_t          q0 [$];
    req_t          q1 [$];
    int            grant_log [$];
    int            exp_log [$];
    bit            obs_r0, obs_r1;
    int            pa_left;
    logic [AW-1:0] pa_addr_cfg;
    logic [DW-1:0] pa_data_cfg;
    bit            pa_rand;

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 1;
        m_beats   = 0;
        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic drive_inputs();
        req_t f;
        for (int n = 0; n < 2; n++) begin
            if ((n == 0 ? q0.size() : q1.size()) != 0) begin
                f = (n == 0) ? q0[0] : q1[0];
                tv[n] = 1'b1; tw[n] = f.w; tl[n] = f.lk; ta[n] = f.a; td[n] = f.d;
            end else begin
                tv[n] = 1'b0; tw[n] = 1'($urandom); tl[n] = 1'($urandom);
                ta[n] = AW'($urandom); td[n] = DW'($urandom);
            end
        end
        if (pa_left > 0) begin
            pa_w = 1'b1; pa_a = pa_addr_cfg; pa_d = pa_data_cfg;
            pa_left--;
        end else if (pa_rand) begin
            pa_w = ($urandom % 3) == 0; pa_a = AW'($urandom % 8); pa_d = DW'($urandom);
        end else begin
            pa_w = 1'b0; pa_a = AW'($urandom); pa_d = DW'($urandom);
        end
    endtask

    task automatic eval_cycle();
        int cand;
        bit coll, er0, er1;
        #4;
        if (m_owner >= 0 && !tv[m_owner]) begin
            m_owner = -1;
            m_beats = 0;
        end
        if (m_owner >= 0)          cand = m_owner;
        else if (tv[0] && tv[1])   cand = 1 - m_last;
        else if (tv[0])            cand = 0;
        else if (tv[1])            cand = 1;
        else                       cand = -1;
        coll = (cand >= 0) && tw[cand] && pa_w && (ta[cand] == pa_a);
        er0  = (cand == 0) && !coll;
        er1  = (cand == 1) && !coll;

        check("req0_ready", 32'(req0_ready), 32'(er0));
        check("req1_ready", 32'(req1_ready), 32'(er1));
        check("mem_addr",  32'(mem_addr),  (cand >= 0) ? 32'(ta[cand]) : 32'd0);
        check("mem_wdata", 32'(mem_wdata), (cand >= 0) ? 32'(td[cand]) : 32'd0);
        check("mem_write", 32'(mem_write), 32'((er0 || er1) && tw[cand]));
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        if (req0_ready) grant_log.push_back(int'(mem_addr));
        if (req1_ready) grant_log.push_back(1000 + int'(mem_addr));

        exp_rv[0] = 1'b0;
        exp_rv[1] = 1'b0;
        if (cand >= 0 && !coll) begin
            m_last = cand;
            if (!tw[cand]) begin
                exp_rv[cand] = 1'b1;
                exp_rd[cand] = m_mem[ta[cand]];
            end else begin
                m_mem[ta[cand]] = td[cand];
            end
            if (tl[cand] && (m_beats + 1 < int'(MB))) begin
                m_owner = cand;
                m_beats++;
            end else begin
                m_owner = -1;
                m_beats = 0;
            end
        end
        if (pa_w) m_mem[pa_a] = pa_d;

        @(posedge clock);
        #1;
        check("rsp0_valid", 32'(rsp0_valid), 32'(exp_rv[0]));
        check("rsp1_valid", 32'(rsp1_valid), 32'(exp_rv[1]));
        check("rsp0_rdata", 32'(rsp0_rdata), 32'(exp_rd[0]));
        check("rsp1_rdata", 32'(rsp1_rdata), 32'(exp_rd[1]));
        if (er0) void'(q0.pop_front());
        if (er1) void'(q1.pop_front());
    endtask

    task automatic step();
        drive_inputs();
        eval_cycle();
    endtask

    task automatic run(input int max_cycles);
        int c;
        c = 0;
        while ((q0.size() + q1.size()) != 0 && c < max_cycles) begin
            step();
            c++;
        end
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(grant_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++)
            check(tag, 32'(grant_log[i]), 32'(exp_log[i]));
    endtask

    task automatic push(input int n, input bit w, input bit lk, input int a, input int d);
        req_t r;
        r.w = w; r.lk = lk; r.a = AW'(a); r.d = DW'(d);
        if (n == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    // Holds reset with both requesters asserting writes; nothing may reach port B.
    task automatic apply_reset();
        reset_n = 1'b0;
        tv[0] = 1'b1; tw[0] = 1'b1; ta[0] = AW'(3); td[0] = 16'hFFFF;
        tv[1] = 1'b1; tw[1] = 1'b1; ta[1] = AW'(4); td[1] = 16'hEEEE;
        pa_w = 1'b0;
        #2;
        check("rst_ready0",    32'(req0_ready), 32'd0);
        check("rst_ready1",    32'(req1_ready), 32'd0);
        check("rst_mem_write", 32'(mem_write),  32'd0);
        check("rst_mem_addr",  32'(mem_addr),   32'd0);
        check("rst_mem_wdata", 32'(mem_wdata),  32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        @(posedge clock);
        #1;
        check("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
        check("rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
        q0.delete();
        q1.delete();
        grant_log.delete();
        exp_log.delete();
        pa_left = 0;
        pa_rand = 1'b0;
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int e3 [8];
        n_cmp = 0;
        n_fail = 0;
        reset_n = 1'b1;
        pa_w = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = init_word(i);
        #1;

        // Single read with latency 1
        apply_reset();
        push(0, 1'b0, 1'b0, 5, 0);
        step();
        check("t1_ready0", 32'(obs_r0), 32'd1);
        check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("t1_rsp0_rdata", 32'(rsp0_rdata), 32'h1234);
        check("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
        step();

        // Unlocked round-robin alternation
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 1'b0, 100 + i, 0);
            push(1, 1'b0, 1'b0, 200 + i, 0);
            exp_log.push_back(100 + i);
            exp_log.push_back(1200 + i);
        end
        run(20);
        check_log("t2_order");

        // Locked burst capped at MAX_BURST beats
        apply_reset();
        for (int i = 0; i < 6; i++) push(0, 1'b1, 1'b1, 10 + i, 'hA000 + i);
        push(1, 1'b1, 1'b0, 20, 'hB020);
        push(1, 1'b1, 1'b0, 21, 'hB021);
        e3 = '{10, 11, 12, 13, 1020, 14, 15, 1021};
        foreach (e3[i]) exp_log.push_back(e3[i]);
        run(20);
        check_log("t3_order");
        for (int i = 0; i < 6; i++) check("t3_mem", 32'(env_mem[10 + i]), 32'('hA000 + i));

        // Port A write collision stalls a write but not a read
        apply_reset();
        push(1, 1'b1, 1'b0, 7, 'hBEEF);
        pa_left = 2; pa_addr_cfg = AW'(7); pa_data_cfg = 16'h1111;
        step();
        check("t4_stall1", 32'(obs_r1), 32'd0);
        step();
        check("t4_stall2", 32'(obs_r1), 32'd0);
        step();
        check("t4_accept", 32'(obs_r1), 32'd1);
        check("t4_mem7", 32'(env_mem[7]), 32'hBEEF);
        push(1, 1'b0, 1'b0, 7, 0);
        pa_left = 1; pa_data_cfg = 16'h2222;
        step();
        check("t4_rd_nostall", 32'(obs_r1), 32'd1);
        check("t4_rd_prewrite", 32'(rsp1_rdata), 32'hBEEF);
        check("t4_mem7_a", 32'(env_mem[7]), 32'h2222);

        // Asynchronous reset in the middle of a locked burst
        apply_reset();
        push(0, 1'b0, 1'b1, 30, 0);
        push(0, 1'b0, 1'b1, 31, 0);
        push(0, 1'b1, 1'b1, 40, 'hDEAD);
        step();
        step();
        drive_inputs();
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_ready0", 32'(req0_ready), 32'd0);
        check("t5_mem_write", 32'(mem_write), 32'd0);
        check("t5_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_rsp0_valid", 32'(rsp0_valid), 32'd0);
        @(posedge clock);
        #1;
        check("t5_nowrite", 32'(env_mem[40]), 32'(init_word(40)));
        q0.delete();
        q1.delete();
        grant_log.delete();
        exp_log.delete();
        model_reset();
        reset_n = 1'b1;
        push(0, 1'b0, 1'b0, 50, 0);
        push(1, 1'b0, 1'b0, 51, 0);
        exp_log.push_back(50);
        exp_log.push_back(1051);
        run(10);
        check_log("t5_order");

        // Locked owner dropping valid hands over in the same cycle
        apply_reset();
        push(1, 1'b0, 1'b1, 60, 0);
        step();
        push(0, 1'b0, 1'b0, 61, 0);
        step();
        check("t6_ready0", 32'(obs_r0), 32'd1);
        check("t6_ready1", 32'(obs_r1), 32'd0);
        push(0, 1'b0, 1'b0, 62, 0);
        push(1, 1'b0, 1'b0, 63, 0);
        step();
        check("t6_rr_ready1", 32'(obs_r1), 32'd1);
        run(10);

        // Random traffic with port A write interference
        apply_reset();
        pa_rand = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                if ((n == 0 ? q0.size() : q1.size()) == 0 && ($urandom % 4) != 0)
                    push(n, 1'($urandom), 1'($urandom),
                         (($urandom % 4) == 0) ? int'($urandom % DEPTH) : int'($urandom % 8),
                         int'($urandom % 65536));
            end
            step();
        end
        pa_rand = 1'b0;
        run(40);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
